sdram_port_arbiter: RTL and testbench

//  Two-port scheduler in front of the SDRAM command decoder (control_interface).

---
 rtl/sdram_port_arbiter_pkg.sv | 31 +++
 rtl/sdram_port_arbiter_burst_addr_ptr.sv | 42 ++++
 rtl/sdram_port_arbiter.sv | 107 ++++++++++
 tb/tb_sdram_port_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared encodings for the SDRAM two-port arbiter: decoder commands, FSM states,
// port identifiers and the arbitration rule.
package sdram_port_arbiter_pkg;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'b000,
    CMD_READA  = 3'b001,
    CMD_WRITEA = 3'b010
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_WR = 1'b0,
    PORT_RD = 1'b1
  } port_t;

  // Urgent read overrides; a tie goes to the port that was not served last.
  function automatic port_t pick_winner(input logic wr_req, input logic rd_req,
                                        input logic rd_urgent, input port_t last);
    if (rd_urgent && rd_req)  return PORT_RD;
    else if (wr_req && rd_req) return (last == PORT_WR) ? PORT_RD : PORT_WR;
    else if (wr_req)           return PORT_WR;
    else                       return PORT_RD;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_burst_addr_ptr.sv
// Burst start-address pointer confined to the window [BASE, MAX); wraps to BASE
// rather than issuing a burst that would cross MAX.
module burst_addr_ptr #(
  parameter int ASIZE = 23,
  parameter int BASE  = 0,
  parameter int MAX   = 640*480,
  parameter int BURST = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_adv,
  output logic [ASIZE-1:0] o_ptr
);

  localparam logic [ASIZE-1:0] L_BASE  = ASIZE'(BASE);
  localparam logic [ASIZE:0]   L_BURST = (ASIZE+1)'(BURST);
  localparam logic [ASIZE:0]   L_MAX   = (ASIZE+1)'(MAX);

  logic [ASIZE-1:0] r_ptr;
  logic [ASIZE:0]   w_sum;
  logic [ASIZE:0]   w_end;
  logic [ASIZE-1:0] w_next;

  // One extra bit keeps the end-of-next-burst compare free of overflow.
  assign w_sum  = {1'b0, r_ptr} + L_BURST;
  assign w_end  = w_sum + L_BURST;
  assign w_next = (w_end > L_MAX) ? L_BASE : w_sum[ASIZE-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= L_BASE;
    end else if (i_load) begin
      r_ptr <= L_BASE;
    end else if (i_adv) begin
      r_ptr <= w_next;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port (camera write / display read) scheduler sharing one SDRAM command
// decoder; one burst command outstanding at a time, gated by SDRAM init.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int ASIZE   = 23,
  parameter int BURST   = 256,
  parameter int WR_BASE = 0,
  parameter int WR_MAX  = 640*480,
  parameter int RD_BASE = 0,
  parameter int RD_MAX  = 640*480
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             Sdram_Init_Done,
  input  logic             WR_REQ,
  input  logic             WR_LOAD,
  input  logic             RD_REQ,
  input  logic             RD_URGENT,
  input  logic             RD_LOAD,
  output logic [2:0]       CMD,
  output logic [ASIZE-1:0] ADDR,
  input  logic             CMD_ACK,
  output logic             WR_GNT,
  output logic             RD_GNT,
  output logic             WR_DONE,
  output logic             RD_DONE,
  output logic [1:0]       DBG_STATE
);

  // Handshake: CMD != NOP acts as valid, CMD_ACK as a single-cycle ready. CMD and
  // ADDR hold until the accept edge; CMD_ACK outside ISSUE is ignored.
  state_t           r_state;
  cmd_t             r_cmd;
  logic [ASIZE-1:0] r_addr;
  port_t            r_win;
  port_t            r_last;
  logic             r_wr_gnt, r_rd_gnt, r_wr_done, r_rd_done;

  logic [ASIZE-1:0] w_wr_ptr, w_rd_ptr;
  logic             w_accept, w_wr_adv, w_rd_adv;
  port_t            w_win;

  assign w_accept = (r_state == ST_ISSUE) && CMD_ACK;
  assign w_wr_adv = w_accept && (r_win == PORT_WR);
  assign w_rd_adv = w_accept && (r_win == PORT_RD);
  assign w_win    = pick_winner(WR_REQ, RD_REQ, RD_URGENT, r_last);

  burst_addr_ptr #(.ASIZE(ASIZE), .BASE(WR_BASE), .MAX(WR_MAX), .BURST(BURST)) u_wr_ptr (
    .clk(CLK), .rst_n(RESET_N), .i_load(WR_LOAD), .i_adv(w_wr_adv), .o_ptr(w_wr_ptr)
  );

  burst_addr_ptr #(.ASIZE(ASIZE), .BASE(RD_BASE), .MAX(RD_MAX), .BURST(BURST)) u_rd_ptr (
    .clk(CLK), .rst_n(RESET_N), .i_load(RD_LOAD), .i_adv(w_rd_adv), .o_ptr(w_rd_ptr)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= ST_IDLE;
      r_cmd     <= CMD_NOP;
      r_addr    <= '0;
      r_win     <= PORT_WR;
      r_last    <= PORT_WR;
      r_wr_gnt  <= 1'b0;
      r_rd_gnt  <= 1'b0;
      r_wr_done <= 1'b0;
      r_rd_done <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      r_rd_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Sdram_Init_Done && (WR_REQ || RD_REQ)) begin
            r_win    <= w_win;
            r_last   <= w_win;
            r_cmd    <= (w_win == PORT_RD) ? CMD_READA : CMD_WRITEA;
            r_addr   <= (w_win == PORT_RD) ? w_rd_ptr : w_wr_ptr;
            r_wr_gnt <= (w_win == PORT_WR);
            r_rd_gnt <= (w_win == PORT_RD);
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (CMD_ACK) begin
            r_cmd     <= CMD_NOP;
            r_wr_gnt  <= 1'b0;
            r_rd_gnt  <= 1'b0;
            r_wr_done <= (r_win == PORT_WR);
            r_rd_done <= (r_win == PORT_RD);
            r_state   <= ST_GAP;
          end
        end
        ST_GAP:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign CMD       = r_cmd;
  assign ADDR      = r_addr;
  assign WR_GNT    = r_wr_gnt;
  assign RD_GNT    = r_rd_gnt;
  assign WR_DONE   = r_wr_done;
  assign RD_DONE   = r_rd_done;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: init gate, handshake, a fixed vector table,
// reset/init-drop sequences and randomized traffic against a window model.
module tb_sdram_port_arbiter;

  localparam int ASIZE   = 23;
  localparam int BURST   = 256;
  localparam int WR_BASE = 0;
  localparam int WR_MAX  = 1024;
  localparam int RD_BASE = 0;
  localparam int RD_MAX  = 1536;
  localparam logic [2:0] C_NOP = 3'b000;
  localparam logic [2:0] C_RD  = 3'b001;
  localparam logic [2:0] C_WR  = 3'b010;

  logic             CLK, RESET_N, Sdram_Init_Done;
  logic             WR_REQ, WR_LOAD, RD_REQ, RD_URGENT, RD_LOAD, CMD_ACK;
  logic [2:0]       CMD;
  logic [ASIZE-1:0] ADDR;
  logic             WR_GNT, RD_GNT, WR_DONE, RD_DONE;
  logic [1:0]       DBG_STATE;

  sdram_port_arbiter #(
    .ASIZE(ASIZE), .BURST(BURST), .WR_BASE(WR_BASE), .WR_MAX(WR_MAX),
    .RD_BASE(RD_BASE), .RD_MAX(RD_MAX)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .Sdram_Init_Done(Sdram_Init_Done),
    .WR_REQ(WR_REQ), .WR_LOAD(WR_LOAD), .RD_REQ(RD_REQ), .RD_URGENT(RD_URGENT),
    .RD_LOAD(RD_LOAD), .CMD(CMD), .ADDR(ADDR), .CMD_ACK(CMD_ACK),
    .WR_GNT(WR_GNT), .RD_GNT(RD_GNT), .WR_DONE(WR_DONE), .RD_DONE(RD_DONE),
    .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RESET_N = 1'b0;
    WR_REQ = 0; RD_REQ = 0; RD_URGENT = 0; WR_LOAD = 0; RD_LOAD = 0; CMD_ACK = 0;
    repeat (3) tick();
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver: one complete command ----------------
  task automatic do_txn(input bit wr, input bit rd, input bit urg, input int dly,
                        input bit lw, input bit lr, input bit drop_req, input bit spur_ack,
                        input bit drop_init, input logic [2:0] ecmd,
                        input logic [ASIZE-1:0] eaddr, input string tag);
    WR_REQ = wr; RD_REQ = rd; RD_URGENT = urg;
    tick();
    chk({tag, " grant cmd"}, CMD, ecmd);
    chk({tag, " grant addr"}, ADDR, eaddr);
    chk({tag, " grant gnt"}, {WR_GNT, RD_GNT}, {ecmd == C_WR, ecmd == C_RD});
    if (drop_req) begin
      WR_REQ = 0; RD_REQ = 0; RD_URGENT = 0;
    end
    if (drop_init) Sdram_Init_Done = 1'b0;
    for (int i = 0; i < dly; i++) begin
      tick();
      chk({tag, " hold cmd"}, CMD, ecmd);
      chk({tag, " hold addr"}, ADDR, eaddr);
      chk({tag, " hold done"}, {WR_DONE, RD_DONE}, 2'b00);
    end
    CMD_ACK = 1'b1; WR_LOAD = lw; RD_LOAD = lr;
    tick();
    CMD_ACK = spur_ack; WR_LOAD = 0; RD_LOAD = 0;
    chk({tag, " accept cmd"}, CMD, C_NOP);
    chk({tag, " accept gnt"}, {WR_GNT, RD_GNT}, 2'b00);
    chk({tag, " accept done"}, {WR_DONE, RD_DONE}, {ecmd == C_WR, ecmd == C_RD});
    tick();
    CMD_ACK = 1'b0;
    chk({tag, " gap cmd"}, CMD, C_NOP);
    chk({tag, " gap done"}, {WR_DONE, RD_DONE}, 2'b00);
    WR_REQ = 0; RD_REQ = 0; RD_URGENT = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit               wr, rd, urg;
    int               dly;
    bit               lw, lr;
    logic [2:0]       cmd;
    logic [ASIZE-1:0] addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit wr, input bit rd, input bit urg, input int dly,
                              input bit lw, input bit lr, input logic [2:0] c, input int a);
    vec_t v;
    v.wr = wr; v.rd = rd; v.urg = urg; v.dly = dly; v.lw = lw; v.lr = lr;
    v.cmd = c; v.addr = a[ASIZE-1:0];
    return v;
  endfunction

  // ---------------- reference model: burst indices inside each window ----------------
  int  m_wr_idx, m_rd_idx;
  bit  m_last_rd;
  localparam int N_WR = (WR_MAX - WR_BASE) / BURST;
  localparam int N_RD = (RD_MAX - RD_BASE) / BURST;

  initial begin
    Sdram_Init_Done = 1'b0;
    apply_reset();

    chk("reset cmd", CMD, C_NOP);
    chk("reset addr", ADDR, 0);
    chk("reset gnt", {WR_GNT, RD_GNT}, 2'b00);
    chk("reset done", {WR_DONE, RD_DONE}, 2'b00);
    chk("reset state", DBG_STATE, 2'd0);

    // Init gate, then a slow handshake on the first write.
    WR_REQ = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("init gate cmd", CMD, C_NOP);
    end
    Sdram_Init_Done = 1'b1;
    do_txn(1, 0, 0, 7, 0, 0, 0, 0, 0, C_WR, 0, "init_first");

    // Fixed vectors from reset: last=WR, wr window 0..768, rd window 0..1280.
    apply_reset();
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, C_RD, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, C_WR, 0));
    tbl.push_back(mk(1, 1, 0, 2, 0, 0, C_RD, 256));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, C_WR, 256));
    tbl.push_back(mk(1, 1, 1, 3, 0, 0, C_RD, 512));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, C_RD, 768));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, C_WR, 512));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, C_WR, 768));
    tbl.push_back(mk(1, 0, 0, 2, 0, 0, C_WR, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, C_RD, 1024));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, C_RD, 1280));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, C_RD, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, C_WR, 256));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, C_WR, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, C_WR, 256));
    tbl.push_back(mk(0, 1, 0, 2, 0, 1, C_RD, 256));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, C_WR, 512));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, C_RD, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      do_txn(tbl[i].wr, tbl[i].rd, tbl[i].urg, tbl[i].dly, tbl[i].lw, tbl[i].lr,
             bit'(i % 2), bit'(i % 3 == 0), 0, tbl[i].cmd, tbl[i].addr,
             $sformatf("vec%0d", i));
    end

    // Async reset in the middle of an outstanding read (rd pointer is at 256).
    RD_REQ = 1'b1;
    tick();
    chk("rst pre cmd", CMD, C_RD);
    chk("rst pre addr", ADDR, 256);
    RD_REQ = 1'b0;
    tick();
    #2 RESET_N = 1'b0;
    #1;
    chk("rst async cmd", CMD, C_NOP);
    chk("rst async gnt", {WR_GNT, RD_GNT}, 2'b00);
    chk("rst async done", {WR_DONE, RD_DONE}, 2'b00);
    repeat (2) begin
      tick();
      chk("rst held cmd", CMD, C_NOP);
      chk("rst held done", {WR_DONE, RD_DONE}, 2'b00);
    end
    RESET_N = 1'b1;
    do_txn(0, 1, 0, 1, 0, 0, 0, 0, 0, C_RD, RD_BASE, "post_rst_rd");
    do_txn(1, 0, 0, 0, 0, 0, 0, 0, 0, C_WR, WR_BASE, "post_rst_wr");

    // Init drops while a read is outstanding: it still completes, then no grants.
    do_txn(1, 1, 0, 3, 0, 0, 1, 0, 1, C_RD, 256, "init_drop");
    WR_REQ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("init low cmd", CMD, C_NOP);
    end
    WR_REQ = 1'b0;
    Sdram_Init_Done = 1'b1;

    // Randomized traffic against the window model.
    apply_reset();
    m_wr_idx = 0; m_rd_idx = 0; m_last_rd = 0;
    for (int n = 0; n < 60; n++) begin
      bit wr, rd, urg, lw, lr, win_rd;
      int dly;
      int eaddr;
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          WR_LOAD = 1'b1; m_wr_idx = 0;
        end else begin
          RD_LOAD = 1'b1; m_rd_idx = 0;
        end
        tick();
        WR_LOAD = 1'b0; RD_LOAD = 1'b0;
        chk("rand idle load cmd", CMD, C_NOP);
      end
      wr  = bit'($urandom_range(0, 1));
      rd  = bit'($urandom_range(0, 1));
      if (!wr && !rd) wr = 1'b1;
      urg = ($urandom_range(0, 3) == 0);
      lw  = ($urandom_range(0, 7) == 0);
      lr  = ($urandom_range(0, 7) == 0);
      dly = $urandom_range(0, 4);
      if (urg && rd)     win_rd = 1'b1;
      else if (wr && rd) win_rd = !m_last_rd;
      else               win_rd = rd;
      eaddr = win_rd ? (RD_BASE + m_rd_idx * BURST) : (WR_BASE + m_wr_idx * BURST);
      do_txn(wr, rd, urg, dly, lw, lr, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             0, win_rd ? C_RD : C_WR, eaddr[ASIZE-1:0], $sformatf("rand%0d", n));
      if (win_rd) m_rd_idx = (m_rd_idx + 1) % N_RD;
      else        m_wr_idx = (m_wr_idx + 1) % N_WR;
      if (lw) m_wr_idx = 0;
      if (lr) m_rd_idx = 0;
      m_last_rd = win_rd;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
